// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings and constants for the PC fetch unit: FSM state codes,
// default reset PC and the instruction word width.
package pc_fetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_S_BOOT = 2'b00,
        FETCH_S_REQ  = 2'b01,
        FETCH_S_HOLD = 2'b10,
        FETCH_S_ERR  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Memory-side and decode-side handshake bundle of the PC fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface pc_fetch_unit_if;
    import pc_fetch_unit_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;

    logic [31:0]        npc_in;
    logic [31:0]        pc_out;
    logic [31:0]        pcplus4_out;
    logic               addr_err;
    logic [31:0]        bad_addr;

    modport master (
        output imem_req, imem_addr, instr_out, instr_valid,
               pc_out, pcplus4_out, addr_err, bad_addr,
        input  imem_ack, imem_rdata, instr_ready, npc_in
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, instr_valid,
               pc_out, pcplus4_out, addr_err, bad_addr,
        output imem_ack, imem_rdata, instr_ready, npc_in
    );

endinterface

// File: rtl/pc_fetch_unit_fetch_perf_cnt.sv
// Fetch and stall event counters for the PC fetch unit (used only when
// FETCH_PERF_EN is defined). Counters wrap and stop counting once in S_ERR.
module fetch_perf_cnt
    import pc_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  fetch_state_t state,
    input  logic         imem_ack,
    input  logic         instr_ready,
    output logic [31:0]  fetch_cnt,
    output logic [31:0]  stall_cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                FETCH_S_REQ: begin
                    if (imem_ack) fetch_cnt <= fetch_cnt + 32'd1;
                    else          stall_cnt <= stall_cnt + 32'd1;
                end
                FETCH_S_HOLD: begin
                    if (!instr_ready) stall_cnt <= stall_cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch FSM between instruction memory and decode.
// Optional perf counters are built when FETCH_PERF_EN is defined.
//
// state        | meaning
// FETCH_S_BOOT | one idle cycle after reset, no request
// FETCH_S_REQ  | request outstanding at pc_out, waiting for imem_ack
// FETCH_S_HOLD | instruction held for decode, waiting for instr_ready
// FETCH_S_ERR  | misaligned next PC seen; terminal until reset
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_unit_if.master      bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    fetch_state_t       state;
    logic [31:0]        pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               req_q;
    logic               err_q;
    logic [31:0]        bad_q;

    // Every output comes straight from a register; nothing is decoded from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH_S_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= '0;
        end else begin
            case (state)
                FETCH_S_BOOT: begin
                    state <= FETCH_S_REQ;
                    req_q <= 1'b1;
                end
                FETCH_S_REQ: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= FETCH_S_HOLD;
                    end
                end
                FETCH_S_HOLD: begin
                    if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        if (bus.npc_in[1:0] == 2'b00) begin
                            pc_q  <= bus.npc_in;
                            req_q <= 1'b1;
                            state <= FETCH_S_REQ;
                        end else begin
                            err_q <= 1'b1;
                            bad_q <= bus.npc_in;
                            state <= FETCH_S_ERR;
                        end
                    end
                end
                FETCH_S_ERR: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: begin
                    state   <= FETCH_S_BOOT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_q;
    assign bus.pcplus4_out = pc_q + 32'd4;
    assign bus.addr_err    = err_q;
    assign bus.bad_addr    = bad_q;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .imem_ack    (bus.imem_ack),
        .instr_ready (bus.instr_ready),
        .fetch_cnt   (perf_fetch_cnt),
        .stall_cnt   (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected fetches are queued when the
// memory response is driven and checked when decode sees instr_valid.
module tb_pc_fetch_unit;

    logic clk;
    logic rst;

    pc_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] f_snap;
    logic [31:0] s_snap;
`endif

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_t;

    fetch_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] word);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        sb.push_back({pc, word});
    endtask

    task automatic pop_check(input string tag);
        fetch_t e;
        chk({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_instr"}, bus.instr_out, e.word);
            chk({tag, "_pc"}, bus.pc_out, e.pc);
            chk({tag, "_pcplus4"}, bus.pcplus4_out, e.pc + 32'd4);
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.npc_in       = '0;
        bus.instr_ready  = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;

        @(negedge clk);
        chk("rst_pc",      bus.pc_out, 32'h0);
        chk("rst_instr",   bus.instr_out, 32'h0);
        chk("rst_valid",   {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_req",     {31'd0, bus.imem_req}, 32'd0);
        chk("rst_err",     {31'd0, bus.addr_err}, 32'd0);
        chk("rst_bad",     bus.bad_addr, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_f",  perf_fetch_cnt, 32'd0);
        chk("rst_perf_s",  perf_stall_cnt, 32'd0);
`endif

        // Boot, zero-wait fetch at RESET_PC
        rst = 1'b0;
        chk("boot_req", {31'd0, bus.imem_req}, 32'd0);
        push_fetch(32'h0, 32'h2008_0005);
        @(negedge clk);
        chk("req0_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("req0_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        pop_check("f0");
        chk("hold0_req", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.npc_in      = 32'h10;

        // Three memory wait cycles at 0x10
        @(negedge clk);
        bus.instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
        f_snap = perf_fetch_cnt;
        s_snap = perf_stall_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("wait_req",   {31'd0, bus.imem_req}, 32'd1);
            chk("wait_addr",  bus.imem_addr, 32'h10);
            chk("wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        end
        push_fetch(32'h10, 32'hA5A5_0010);
        @(negedge clk);
        pop_check("f1");
        bus.imem_ack = 1'b0;
`ifdef FETCH_PERF_EN
        chk("perf_stall_wait", perf_stall_cnt - s_snap, 32'd3);
        chk("perf_fetch_wait", perf_fetch_cnt - f_snap, 32'd1);
        s_snap = perf_stall_cnt;
`endif

        // Decode back-pressure for two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_instr", bus.instr_out, 32'hA5A5_0010);
            chk("bp_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("bp_pc",    bus.pc_out, 32'h10);
            chk("bp_req",   {31'd0, bus.imem_req}, 32'd0);
        end
`ifdef FETCH_PERF_EN
        chk("perf_stall_bp", perf_stall_cnt - s_snap, 32'd2);
`endif
        bus.instr_ready = 1'b1;
        bus.npc_in      = 32'h40;
        @(negedge clk);
        chk("npc40_pc",    bus.pc_out, 32'h40);
        chk("npc40_addr",  bus.imem_addr, 32'h40);
        chk("npc40_req",   {31'd0, bus.imem_req}, 32'd1);
        chk("npc40_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.instr_ready = 1'b0;
        push_fetch(32'h40, 32'h0000_0013);
        @(negedge clk);
        pop_check("f2");
        bus.imem_ack    = 1'b0;

        // Self-loop refetch of the same address
        bus.instr_ready = 1'b1;
        bus.npc_in      = 32'h40;
        @(negedge clk);
        chk("self_addr", bus.imem_addr, 32'h40);
        chk("self_req",  {31'd0, bus.imem_req}, 32'd1);
        bus.instr_ready = 1'b0;
        push_fetch(32'h40, 32'h1234_5678);
        @(negedge clk);
        pop_check("f3");
        bus.imem_ack    = 1'b0;

        // Top-of-memory PC; pcplus4 wraps
        bus.instr_ready = 1'b1;
        bus.npc_in      = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("wrap_pc",      bus.pc_out, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", bus.pcplus4_out, 32'h0);
        chk("wrap_addr",    bus.imem_addr, 32'hFFFF_FFFC);
        // ready with a bad npc while not valid must be ignored
        bus.npc_in = 32'h42;
        @(negedge clk);
        chk("ign_err", {31'd0, bus.addr_err}, 32'd0);
        chk("ign_pc",  bus.pc_out, 32'hFFFF_FFFC);
        chk("ign_req", {31'd0, bus.imem_req}, 32'd1);
        bus.instr_ready = 1'b0;
        push_fetch(32'hFFFF_FFFC, 32'hCAFE_F00D);
        @(negedge clk);
        pop_check("f4");
        bus.imem_ack = 1'b0;

        // Misaligned next PC
        bus.instr_ready = 1'b1;
        bus.npc_in      = 32'h0000_0042;
`ifdef FETCH_PERF_EN
        f_snap = perf_fetch_cnt;
        s_snap = perf_stall_cnt;
`endif
        @(negedge clk);
        chk("err_flag",  {31'd0, bus.addr_err}, 32'd1);
        chk("err_bad",   bus.bad_addr, 32'h42);
        chk("err_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("err_pc",    bus.pc_out, 32'hFFFF_FFFC);
        bus.imem_ack    = 1'b1;
        bus.npc_in      = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_req_stuck",   {31'd0, bus.imem_req}, 32'd0);
            chk("err_valid_stuck", {31'd0, bus.instr_valid}, 32'd0);
            chk("err_bad_stuck",   bus.bad_addr, 32'h42);
        end
`ifdef FETCH_PERF_EN
        chk("perf_freeze_f", perf_fetch_cnt, f_snap);
        chk("perf_freeze_s", perf_stall_cnt, s_snap);
`endif
        rst = 1'b1;
        #1;
        chk("clr_pc",   bus.pc_out, 32'h0);
        chk("clr_err",  {31'd0, bus.addr_err}, 32'd0);
        chk("clr_bad",  bus.bad_addr, 32'h0);
        chk("clr_req",  {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;

        // Reset in the middle of a request at 0x80
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_fetch(32'h0, 32'h0BAD_0001);
        @(negedge clk);
        pop_check("f5");
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        bus.npc_in      = 32'h80;
        @(negedge clk);
        chk("mid_pc",  bus.pc_out, 32'h80);
        chk("mid_req", {31'd0, bus.imem_req}, 32'd1);
        bus.instr_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_pc",    bus.pc_out, 32'h0);
        chk("mid_rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        chk("late_ack_req", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);
        chk("late_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("late_ack_instr", bus.instr_out, 32'h0);
        chk("late_ack_pc",    bus.pc_out, 32'h0);
        bus.imem_ack = 1'b0;
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
